// File: rtl/sdram_arbiter.sv
// Two-client request arbiter in front of a single-outstanding SDRAM controller port.
// Build option SDRAM_ARB_FIXED_PRIO_EN: client 0 always wins ties; default is round-robin.
module sdram_arbiter #(
  parameter int ADDR_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [1:0]        c0_wbyte_addr,
  input  logic              c0_rw,
  input  logic [31:0]       c0_data_in,
  input  logic              c0_in_valid,
  output logic              c0_busy,
  output logic              c0_out_valid,
  output logic [31:0]       c0_data_out,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [1:0]        c1_wbyte_addr,
  input  logic              c1_rw,
  input  logic [31:0]       c1_data_in,
  input  logic              c1_in_valid,
  output logic              c1_busy,
  output logic              c1_out_valid,
  output logic [31:0]       c1_data_out,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [1:0]        sd_wbyte_addr,
  output logic              sd_rw,
  output logic [31:0]       sd_data_in,
  output logic              sd_in_valid,
  input  logic              sd_busy,
  input  logic              sd_out_valid,
  input  logic [31:0]       sd_data_out
);
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT_RD} state_t;

  logic [ADDR_W-1:0] in_addr [2];
  logic [1:0]        in_wbyte [2];
  logic [31:0]       in_data [2];
  logic [1:0]        in_rw, in_valid;

  logic [ADDR_W-1:0] slot_addr [2];
  logic [1:0]        slot_wbyte [2];
  logic [31:0]       slot_data [2];
  logic [31:0]       data_out [2];
  logic [1:0]        slot_rw, full, busy, out_valid;

  state_t            state_q, state_d;
  logic              grant_q, grant_d, pick, issue_load, rd_done;
  logic              sd_in_valid_q, sd_rw_q;
  logic [ADDR_W-1:0] sd_addr_q;
  logic [1:0]        sd_wbyte_q;
  logic [31:0]       sd_data_q;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
  logic              last_q, last_d;
`endif

  assign in_addr[0]  = c0_addr;
  assign in_addr[1]  = c1_addr;
  assign in_wbyte[0] = c0_wbyte_addr;
  assign in_wbyte[1] = c1_wbyte_addr;
  assign in_data[0]  = c0_data_in;
  assign in_data[1]  = c1_data_in;
  assign in_rw       = {c1_rw, c0_rw};
  assign in_valid    = {c1_in_valid, c0_in_valid};

  always_comb begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    pick = ~full[0];
`else
    pick   = (full == 2'b11) ? ~last_q : ~full[0];
    last_d = last_q;
`endif
    state_d    = state_q;
    grant_d    = grant_q;
    issue_load = 1'b0;
    rd_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|full) && !sd_busy) begin
          state_d    = ISSUE;
          grant_d    = pick;
          issue_load = 1'b1;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
          last_d     = pick;
`endif
        end
      end
      ISSUE:   state_d = SETTLE;
      // sd_busy lags acceptance by a cycle, so it is not trusted here
      SETTLE:  state_d = sd_rw_q ? IDLE : WAIT_RD;
      WAIT_RD: begin
        if (sd_out_valid) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      sd_in_valid_q <= 1'b0;
      sd_rw_q       <= 1'b0;
      sd_addr_q     <= '0;
      sd_wbyte_q    <= '0;
      sd_data_q     <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      last_q        <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      sd_in_valid_q <= issue_load;
      if (issue_load) begin
        sd_addr_q  <= slot_addr[pick];
        sd_wbyte_q <= slot_wbyte[pick];
        sd_rw_q    <= slot_rw[pick];
        sd_data_q  <= slot_data[pick];
      end
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      last_q        <= last_d;
`endif
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_client
      localparam logic ID = 1'(gi);
      logic              full_q, pend_q, ov_q, rw_q;
      logic [ADDR_W-1:0] addr_q;
      logic [1:0]        wbyte_q;
      logic [31:0]       data_q, dout_q;
      logic              capture, clear, mine_done;

      assign capture   = in_valid[gi] & ~busy[gi];
      assign clear     = (state_q == ISSUE) && (grant_q == ID);
      assign mine_done = rd_done && (grant_q == ID);

      // pend_q covers a read from grant until its out_valid pulse has been seen
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          full_q  <= 1'b0;
          pend_q  <= 1'b0;
          ov_q    <= 1'b0;
          rw_q    <= 1'b0;
          addr_q  <= '0;
          wbyte_q <= '0;
          data_q  <= '0;
          dout_q  <= '0;
        end else begin
          if (capture) begin
            full_q  <= 1'b1;
            addr_q  <= in_addr[gi];
            wbyte_q <= in_wbyte[gi];
            rw_q    <= in_rw[gi];
            data_q  <= in_data[gi];
          end else if (clear) begin
            full_q  <= 1'b0;
          end
          if (issue_load && (pick == ID) && !rw_q) pend_q <= 1'b1;
          else if (ov_q)                           pend_q <= 1'b0;
          ov_q <= mine_done;
          if (mine_done) dout_q <= sd_data_out;
        end
      end

      assign busy[gi]       = full_q | pend_q;
      assign full[gi]       = full_q;
      assign slot_rw[gi]    = rw_q;
      assign slot_addr[gi]  = addr_q;
      assign slot_wbyte[gi] = wbyte_q;
      assign slot_data[gi]  = data_q;
      assign out_valid[gi]  = ov_q;
      assign data_out[gi]   = dout_q;
    end
  endgenerate

  assign c0_busy       = busy[0];
  assign c1_busy       = busy[1];
  assign c0_out_valid  = out_valid[0];
  assign c1_out_valid  = out_valid[1];
  assign c0_data_out   = data_out[0];
  assign c1_data_out   = data_out[1];
  assign sd_in_valid   = sd_in_valid_q;
  assign sd_addr       = sd_addr_q;
  assign sd_wbyte_addr = sd_wbyte_q;
  assign sd_rw         = sd_rw_q;
  assign sd_data_in    = sd_data_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomised bench for sdram_arbiter: a transaction-level model of slots, grants and
// the downstream port predicts every output each cycle; a simple SDRAM responder drives sd_*.
module tb_sdram_arbiter;
  localparam int AW = 23;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] cl_addr [2];
  logic [1:0]    cl_wb [2];
  logic [31:0]   cl_din [2];
  logic [1:0]    cl_rw, cl_valid;

  logic          c0_busy, c0_out_valid, c1_busy, c1_out_valid;
  logic [31:0]   c0_data_out, c1_data_out;
  logic [AW-1:0] sd_addr;
  logic [1:0]    sd_wbyte_addr;
  logic          sd_rw, sd_in_valid, sd_busy, sd_out_valid;
  logic [31:0]   sd_data_in, sd_data_out;

  logic [1:0]    d_busy, d_ov;
  logic [31:0]   d_dout [2];
  assign d_busy    = {c1_busy, c0_busy};
  assign d_ov      = {c1_out_valid, c0_out_valid};
  assign d_dout[0] = c0_data_out;
  assign d_dout[1] = c1_data_out;

  sdram_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .c0_addr(cl_addr[0]), .c0_wbyte_addr(cl_wb[0]), .c0_rw(cl_rw[0]), .c0_data_in(cl_din[0]),
    .c0_in_valid(cl_valid[0]), .c0_busy(c0_busy), .c0_out_valid(c0_out_valid), .c0_data_out(c0_data_out),
    .c1_addr(cl_addr[1]), .c1_wbyte_addr(cl_wb[1]), .c1_rw(cl_rw[1]), .c1_data_in(cl_din[1]),
    .c1_in_valid(cl_valid[1]), .c1_busy(c1_busy), .c1_out_valid(c1_out_valid), .c1_data_out(c1_data_out),
    .sd_addr(sd_addr), .sd_wbyte_addr(sd_wbyte_addr), .sd_rw(sd_rw), .sd_data_in(sd_data_in),
    .sd_in_valid(sd_in_valid), .sd_busy(sd_busy), .sd_out_valid(sd_out_valid), .sd_data_out(sd_data_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state (values for the current cycle)
  bit            m_full [2];
  logic [AW-1:0] m_addr [2];
  logic [1:0]    m_wb [2];
  bit            m_rw [2];
  logic [31:0]   m_din [2];
  bit            m_pend [2];
  bit            m_ov [2];
  logic [31:0]   m_dout [2];
  int            m_age;
  bit            m_rd_wait, m_rd_owner, m_last, m_gnt_v, m_gnt;
  logic [AW-1:0] e_addr;
  logic [1:0]    e_wb;
  logic          e_rw;
  logic [31:0]   e_din;

  int            gnt_log [$];
  int            issue_cnt = 0;
  int            ov_cnt [2] = '{0, 0};

  // downstream responder
  logic [31:0]   mem [logic [AW-1:0]];
  int            ds_cnt, busy_cnt, force_lat;
  bit            hold_busy, rand_busy, stray_en, issued_now, issued_rd;
  logic [AW-1:0] issued_addr, rd_addr;

  task automatic model_init();
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 0; m_addr[k] = '0; m_wb[k] = '0; m_rw[k] = 0; m_din[k] = '0;
      m_pend[k] = 0; m_ov[k] = 0; m_dout[k] = '0;
    end
    m_age = 2; m_rd_wait = 0; m_rd_owner = 0; m_last = 1; m_gnt_v = 0; m_gnt = 0;
    e_addr = '0; e_wb = '0; e_rw = 0; e_din = '0;
    ds_cnt = 0; busy_cnt = 0; issued_now = 0; issued_rd = 0;
  endtask

  task automatic check_and_model();
    bit busy_m [2];
    bit nxt_ov [2];
    int age_now;
    bit idle, ng_v, ng;
    for (int k = 0; k < 2; k++) begin
      busy_m[k] = m_full[k] | m_pend[k];
      check_val($sformatf("c%0d_busy", k), 32'(d_busy[k]), 32'(busy_m[k]));
      check_val($sformatf("c%0d_out_valid", k), 32'(d_ov[k]), 32'(m_ov[k]));
      check_val($sformatf("c%0d_data_out", k), d_dout[k], m_dout[k]);
      if (d_ov[k]) begin
        ov_cnt[k]++;
        $display("read return: client %0d data=0x%08h t=%0t", k, d_dout[k], $time);
      end
    end
    check_val("sd_in_valid", 32'(sd_in_valid), 32'(m_gnt_v));
    if (m_gnt_v) begin
      e_addr = m_addr[m_gnt]; e_wb = m_wb[m_gnt]; e_rw = m_rw[m_gnt]; e_din = m_din[m_gnt];
      gnt_log.push_back(int'(m_gnt));
      issue_cnt++;
      issued_now = 1; issued_rd = !e_rw; issued_addr = e_addr;
      if (e_rw) mem[e_addr] = e_din;
      $display("issue: client %0d %s addr=0x%06h wbyte=%0d data=0x%08h t=%0t",
               m_gnt, e_rw ? "WR" : "RD", e_addr, e_wb, e_din, $time);
    end
    check_val("sd_addr", 32'(sd_addr), 32'(e_addr));
    check_val("sd_wbyte_addr", 32'(sd_wbyte_addr), 32'(e_wb));
    check_val("sd_rw", 32'(sd_rw), 32'(e_rw));
    check_val("sd_data_in", sd_data_in, e_din);

    age_now = m_gnt_v ? 0 : m_age;
    idle = (age_now >= 2) && !m_rd_wait;
    nxt_ov[0] = 0; nxt_ov[1] = 0;
    if (m_rd_wait && age_now >= 2 && sd_out_valid) begin
      nxt_ov[m_rd_owner] = 1;
      m_dout[m_rd_owner] = sd_data_out;
      m_rd_wait = 0;
    end
    ng_v = idle && (m_full[0] || m_full[1]) && !sd_busy;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    ng = (m_full[0] && m_full[1]) ? 1'b0 : !m_full[0];
`else
    ng = (m_full[0] && m_full[1]) ? !m_last : !m_full[0];
`endif
    for (int k = 0; k < 2; k++) if (m_ov[k]) m_pend[k] = 0;
    if (m_gnt_v && !m_rw[m_gnt]) begin
      m_pend[m_gnt] = 1; m_rd_wait = 1; m_rd_owner = m_gnt;
    end
    for (int k = 0; k < 2; k++) begin
      if (cl_valid[k] && !busy_m[k]) begin
        m_full[k] = 1; m_addr[k] = cl_addr[k]; m_wb[k] = cl_wb[k];
        m_rw[k] = cl_rw[k]; m_din[k] = cl_din[k];
      end else if (m_gnt_v && m_gnt == 1'(k)) begin
        m_full[k] = 0;
      end
    end
    m_gnt_v = ng_v;
    m_gnt   = ng;
    if (ng_v) m_last = ng;
    m_age = (age_now < 8) ? age_now + 1 : age_now;
    m_ov  = nxt_ov;
  endtask

  task automatic drive_downstream();
    sd_out_valid = 1'b0;
    sd_data_out  = $urandom();
    if (issued_now) begin
      busy_cnt = $urandom_range(1, 3);
      if (issued_rd) begin
        ds_cnt  = (force_lat > 0) ? force_lat : $urandom_range(2, 8);
        rd_addr = issued_addr;
      end
      issued_now = 0;
    end
    if (ds_cnt > 0) begin
      ds_cnt--;
      if (ds_cnt == 0) begin
        sd_out_valid = 1'b1;
        sd_data_out  = mem.exists(rd_addr) ? mem[rd_addr] : (32'hC0DE0000 ^ 32'(rd_addr));
      end
    end else if (stray_en && !m_rd_wait && $urandom_range(0, 19) == 0) begin
      sd_out_valid = 1'b1;
    end
    if (busy_cnt == 0 && rand_busy && $urandom_range(0, 15) == 0) busy_cnt = $urandom_range(1, 5);
    sd_busy = hold_busy || (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
  endtask

  // entered and left just after a rising edge
  task automatic tick();
    @(negedge clk);
    check_and_model();
    @(posedge clk);
    #1;
    cl_valid = 2'b00;
    drive_downstream();
  endtask

  task automatic submit(input int k, input logic [AW-1:0] a, input logic [1:0] wb,
                        input logic rw, input logic [31:0] d);
    cl_addr[k] = a; cl_wb[k] = wb; cl_rw[k] = rw; cl_din[k] = d; cl_valid[k] = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check_val("rst_c0_busy", 32'(c0_busy), 0);
    check_val("rst_c1_busy", 32'(c1_busy), 0);
    check_val("rst_c0_out_valid", 32'(c0_out_valid), 0);
    check_val("rst_c1_out_valid", 32'(c1_out_valid), 0);
    check_val("rst_c0_data_out", c0_data_out, 0);
    check_val("rst_c1_data_out", c1_data_out, 0);
    check_val("rst_sd_in_valid", 32'(sd_in_valid), 0);
    check_val("rst_sd_addr", 32'(sd_addr), 0);
    check_val("rst_sd_wbyte", 32'(sd_wbyte_addr), 0);
    check_val("rst_sd_rw", 32'(sd_rw), 0);
    check_val("rst_sd_data_in", sd_data_in, 0);
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    check_reset_outputs();
    cl_valid = 2'b00; sd_busy = 1'b0; sd_out_valid = 1'b0; hold_busy = 0;
    model_init();
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base, ov0, ov1, c0_sent, w;
    int exp_r [5];
    rst = 1'b1;
    cl_valid = 2'b00; cl_rw = 2'b00;
    for (int k = 0; k < 2; k++) begin cl_addr[k] = '0; cl_wb[k] = '0; cl_din[k] = '0; end
    sd_busy = 1'b0; sd_out_valid = 1'b0; sd_data_out = '0;
    force_lat = 0; hold_busy = 0; rand_busy = 0; stray_en = 0;
    model_init();
    @(posedge clk);
    #3;
    check_reset_outputs();
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // single write from client 0
    submit(0, 23'h000123, 2'd2, 1'b1, 32'h000000A5);
    repeat (10) tick();
    check_val("w0_issue_cnt", issue_cnt, 1);
    check_val("w0_no_out_valid", ov_cnt[0], 0);

    // read from client 1 answered 6 cycles after issue
    mem[23'h200010] = 32'hDEADBEEF;
    force_lat = 6;
    ov0 = ov_cnt[0]; ov1 = ov_cnt[1];
    submit(1, 23'h200010, 2'd0, 1'b0, 32'h0);
    repeat (16) tick();
    force_lat = 0;
    check_val("r1_out_valid_cnt", ov_cnt[1] - ov1, 1);
    check_val("r1_c0_quiet", ov_cnt[0] - ov0, 0);
    check_val("r1_data", c1_data_out, 32'hDEADBEEF);

    // simultaneous writes, four rounds
    apply_reset();
    gnt_log.delete();
    for (int p = 0; p < 4; p++) begin
      w = 0;
      while ((m_full[0] || m_full[1]) && w < 40) begin tick(); w++; end
      submit(0, AW'(32'h100 + p), 2'd1, 1'b1, 32'hA0000000 + p);
      submit(1, AW'(32'h180 + p), 2'd3, 1'b1, 32'hB0000000 + p);
      tick();
    end
    repeat (12) tick();
    check_val("pair_grant_cnt", gnt_log.size(), 8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++)
      check_val($sformatf("pair_grant_%0d", i), gnt_log[i], i % 2);

    // client 0 refills its slot as fast as it can while client 1 waits
    gnt_log.delete();
    c0_sent = 1;
    submit(0, 23'h300, 2'd0, 1'b1, 32'h30000000);
    submit(1, 23'h380, 2'd0, 1'b1, 32'h38000000);
    tick();
    for (int i = 0; i < 40; i++) begin
      if (c0_sent < 4 && !m_full[0]) begin
        submit(0, AW'(32'h300 + c0_sent), 2'd0, 1'b1, 32'h30000000 + c0_sent);
        c0_sent++;
      end
      tick();
    end
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_r = '{0, 0, 0, 0, 1};
`else
    exp_r = '{0, 1, 0, 0, 0};
`endif
    check_val("refill_grant_cnt", gnt_log.size(), 5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++)
      check_val($sformatf("refill_grant_%0d", i), gnt_log[i], exp_r[i]);

    // downstream busy held for 20 cycles; a second pulse while busy is dropped
    hold_busy = 1; sd_busy = 1'b1;
    base = issue_cnt;
    submit(0, 23'h0000AA, 2'd1, 1'b1, 32'h11112222);
    tick();
    for (int i = 0; i < 20; i++) begin
      if (i == 5) submit(0, 23'h0000BB, 2'd3, 1'b1, 32'h33334444);
      tick();
    end
    check_val("hold_no_issue", issue_cnt - base, 0);
    hold_busy = 0;
    repeat (10) tick();
    check_val("hold_one_issue", issue_cnt - base, 1);
    check_val("hold_issue_data", sd_data_in, 32'h11112222);

    // reset while waiting for read data, then a late sd_out_valid
    force_lat = 50;
    submit(0, 23'h000055, 2'd0, 1'b0, 32'h0);
    tick();
    w = 0;
    while (!(m_rd_wait && m_age >= 2) && w < 20) begin tick(); w++; end
    repeat (3) tick();
    check_val("c0_busy_wait_rd", 32'(c0_busy), 1);
    ov0 = ov_cnt[0]; ov1 = ov_cnt[1];
    force_lat = 0;
    apply_reset();
    sd_out_valid = 1'b1; sd_data_out = 32'h12345678;
    repeat (4) tick();
    check_val("late_rd_c0_ov", ov_cnt[0] - ov0, 0);
    check_val("late_rd_c1_ov", ov_cnt[1] - ov1, 0);
    check_val("late_rd_c0_data", c0_data_out, 0);
    check_val("late_rd_c0_busy", 32'(c0_busy), 0);
    check_val("late_rd_c1_busy", 32'(c1_busy), 0);

    // stray sd_out_valid while idle
    ov0 = ov_cnt[0]; ov1 = ov_cnt[1];
    sd_out_valid = 1'b1; sd_data_out = 32'hCAFEF00D;
    repeat (3) tick();
    check_val("stray_c0_ov", ov_cnt[0] - ov0, 0);
    check_val("stray_c1_ov", ov_cnt[1] - ov1, 0);
    check_val("stray_c1_data", c1_data_out, 0);

    // random traffic
    rand_busy = 1; stray_en = 1;
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 2) == 0)
          submit(k, AW'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom());
      tick();
    end
    rand_busy = 0; stray_en = 0;
    repeat (40) tick();
    check_val("end_c0_busy", 32'(c0_busy), 0);
    check_val("end_c1_busy", 32'(c1_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
